// File: rtl/dialer_pkg.sv
// Shared types for the rotary-dialer session controller.
// Digit layout, widths and the session FSM encoding.
package dialer_pkg;

    localparam int FE_DIGITS = 7;
    localparam int FE_VAL_W  = 16;

    localparam int DIGIT_W [FE_DIGITS] = '{1, 2, 2, 3, 3, 3, 3};

    // index k holds the digit of weight k!
    typedef logic [FE_DIGITS:1][2:0] fe_digits_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_WAIT_BEGIN,
        ST_WAIT_END,
        ST_CONVERT,
        ST_OUTPUT
    } state_e;

    function automatic fe_digits_t pack_digits(
        input logic       d1,
        input logic [1:0] d2,
        input logic [1:0] d3,
        input logic [2:0] d4,
        input logic [2:0] d5,
        input logic [2:0] d6,
        input logic [2:0] d7
    );
        fe_digits_t v;
        v[1] = {2'b00, d1};
        v[2] = {1'b0, d2};
        v[3] = {1'b0, d3};
        v[4] = d4;
        v[5] = d5;
        v[6] = d6;
        v[7] = d7;
        return v;
    endfunction

endpackage

// File: rtl/dialer_session_ctrl_if.sv
// Result channel of the session controller: value plus digit count,
// transferred on res_valid & res_ready.
interface dialer_session_ctrl_if #(
    parameter int VAL_W = 16
);
    logic [VAL_W-1:0] res_value;
    logic [2:0]       res_ndigits;
    logic             res_valid;
    logic             res_ready;

    modport master (
        output res_value,
        output res_ndigits,
        output res_valid,
        input  res_ready
    );

    modport slave (
        input  res_value,
        input  res_ndigits,
        input  res_valid,
        output res_ready
    );
endinterface

// File: rtl/fe_to_bin_seq.sv
// Iterative Horner conversion of a factorial-base number to binary,
// one digit per cycle, six cycles from start to done.
module fe_to_bin_seq
    import dialer_pkg::*;
#(
    parameter int VAL_W = FE_VAL_W
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             start,
    input  fe_digits_t       digits,
    output logic             done,
    output logic [VAL_W-1:0] value
);

    logic [VAL_W-1:0] acc_q, acc_d;
    logic [2:0]       k_q, k_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [VAL_W-1:0] acc_sel;
    logic [2:0]       k_sel;

    // start folds the acc = d7 initialisation into the k = 7 step
    always_comb begin
        acc_sel = start ? VAL_W'(digits[FE_DIGITS]) : acc_q;
        k_sel   = start ? 3'(FE_DIGITS) : k_q;
        acc_d   = acc_q;
        k_d     = k_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (start || busy_q) begin
            acc_d = acc_sel * VAL_W'(k_sel)
                  + VAL_W'(digits[k_sel - 3'd1]);
            if (k_sel == 3'd2) begin
                k_d    = 3'd0;
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                k_d    = k_sel - 3'd1;
                busy_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            k_q    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            k_q    <= k_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign done  = done_q;
    assign value = acc_q;

endmodule

// File: rtl/dialer_session_ctrl.sv
// Drives one dialer front end through clear / dial / capture / convert
// sessions and hands each converted number out over a valid/ready channel.
module dialer_session_ctrl
    import dialer_pkg::*;
#(
    parameter int VAL_W       = FE_VAL_W,
    parameter int RESTART_LEN = 2
) (
    input  logic                  CLK,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  all_digits_have_been_dialed,
    input  logic [2:0]            num_of_digits_dialed,
    input  logic                  of1,
    input  logic [1:0]            of2,
    input  logic [1:0]            of3,
    input  logic [2:0]            of4,
    input  logic [2:0]            of5,
    input  logic [2:0]            of6,
    input  logic [2:0]            of7,
    output logic                  restart,
    output logic                  dialing,
    dialer_session_ctrl_if.master res
);

    localparam int RCNT_W = (RESTART_LEN > 2) ? $clog2(RESTART_LEN) : 1;

    state_e           state_q, state_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic             restart_q, restart_d;
    logic             dialing_q, dialing_d;
    logic             valid_q, valid_d;
    logic [VAL_W-1:0] value_q, value_d;
    logic [2:0]       ndig_q, ndig_d;
    fe_digits_t       cap_q, cap_d;
    logic [2:0]       cap_n_q, cap_n_d;
    logic             start_q, start_d;

    logic             conv_done;
    logic [VAL_W-1:0] conv_value;
    fe_digits_t       dig_in;

    assign dig_in = pack_digits(of1, of2, of3, of4, of5, of6, of7);

    always_comb begin
        state_d   = state_q;
        rcnt_d    = rcnt_q;
        restart_d = restart_q;
        valid_d   = valid_q;
        value_d   = value_q;
        ndig_d    = ndig_q;
        cap_d     = cap_q;
        cap_n_d   = cap_n_q;
        start_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d   = ST_CLEAR;
                    restart_d = 1'b1;
                    rcnt_d    = '0;
                end
            end
            ST_CLEAR: begin
                if (rcnt_q == RCNT_W'(RESTART_LEN - 1)) begin
                    state_d   = ST_WAIT_BEGIN;
                    restart_d = 1'b0;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            ST_WAIT_BEGIN: begin
                if (!all_digits_have_been_dialed) begin
                    state_d = ST_WAIT_END;
                end else if (!enable) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_END: begin
                if (all_digits_have_been_dialed) begin
                    cap_d   = dig_in;
                    cap_n_d = num_of_digits_dialed;
                    if (num_of_digits_dialed != 3'd0) begin
                        state_d = ST_CONVERT;
                        start_d = 1'b1;
                    end else begin
                        state_d   = ST_CLEAR;
                        restart_d = 1'b1;
                        rcnt_d    = '0;
                    end
                end
            end
            ST_CONVERT: begin
                if (conv_done) begin
                    state_d = ST_OUTPUT;
                    valid_d = 1'b1;
                    value_d = conv_value;
                    ndig_d  = cap_n_q;
                end
            end
            ST_OUTPUT: begin
                if (res.res_ready) begin
                    valid_d = 1'b0;
                    if (enable) begin
                        state_d   = ST_CLEAR;
                        restart_d = 1'b1;
                        rcnt_d    = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        dialing_d = state_d inside {ST_WAIT_BEGIN, ST_WAIT_END,
                                    ST_CONVERT, ST_OUTPUT};
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rcnt_q    <= '0;
            restart_q <= 1'b0;
            dialing_q <= 1'b0;
            valid_q   <= 1'b0;
            value_q   <= '0;
            ndig_q    <= '0;
            cap_q     <= '0;
            cap_n_q   <= '0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
            restart_q <= restart_d;
            dialing_q <= dialing_d;
            valid_q   <= valid_d;
            value_q   <= value_d;
            ndig_q    <= ndig_d;
            cap_q     <= cap_d;
            cap_n_q   <= cap_n_d;
            start_q   <= start_d;
        end
    end

    fe_to_bin_seq #(
        .VAL_W (VAL_W)
    ) u_conv (
        .CLK    (CLK),
        .rst_n  (rst_n),
        .start  (start_q),
        .digits (cap_q),
        .done   (conv_done),
        .value  (conv_value)
    );

    assign restart         = restart_q;
    assign dialing         = dialing_q;
    assign res.res_valid   = valid_q;
    assign res.res_value   = value_q;
    assign res.res_ndigits = ndig_q;

endmodule

// File: tb/tb_dialer_session_ctrl.sv
// Directed session sequence against a factorial-weight reference model,
// with expected results queued at capture and checked at each transfer.
module tb_dialer_session_ctrl;

    localparam int VAL_W = 16;

    typedef struct {
        logic [VAL_W-1:0] v;
        logic [2:0]       n;
    } exp_t;

    logic       CLK = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       all_done;
    logic [2:0] ndial;
    logic       of1;
    logic [1:0] of2, of3;
    logic [2:0] of4, of5, of6, of7;
    logic       restart, dialing;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    dialer_session_ctrl_if #(.VAL_W(VAL_W)) res_if ();

    dialer_session_ctrl #(
        .VAL_W       (VAL_W),
        .RESTART_LEN (2)
    ) dut (
        .CLK                         (CLK),
        .rst_n                       (rst_n),
        .enable                      (enable),
        .all_digits_have_been_dialed (all_done),
        .num_of_digits_dialed        (ndial),
        .of1                         (of1),
        .of2                         (of2),
        .of3                         (of3),
        .of4                         (of4),
        .of5                         (of5),
        .of6                         (of6),
        .of7                         (of7),
        .restart                     (restart),
        .dialing                     (dialing),
        .res                         (res_if)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic int fe_value(input int d7, d6, d5, d4, d3, d2, d1);
        return d7 * 5040 + d6 * 720 + d5 * 120 + d4 * 24
             + d3 * 6 + d2 * 2 + d1;
    endfunction

    task automatic set_digits(input int d7, d6, d5, d4, d3, d2, d1);
        of7 = 3'(d7); of6 = 3'(d6); of5 = 3'(d5); of4 = 3'(d4);
        of3 = 2'(d3); of2 = 2'(d2); of1 = 1'(d1);
    endtask

    // WAIT_BEGIN -> WAIT_END -> capture edge; digits are scrambled after
    // capture so a design that reads the live inputs gets caught
    task automatic dial(input int d7, d6, d5, d4, d3, d2, d1,
                        input int cnt, input bit push);
        exp_t e;
        all_done = 1'b0;
        tick();
        set_digits(d7, d6, d5, d4, d3, d2, d1);
        ndial = 3'(cnt);
        all_done = 1'b1;
        tick();
        if (push) begin
            e.v = VAL_W'(fe_value(d7, d6, d5, d4, d3, d2, d1));
            e.n = 3'(cnt);
            sb.push_back(e);
        end
        set_digits(7, 7, 7, 7, 3, 3, 1);
        ndial = 3'd5;
    endtask

    task automatic wait_valid(input string tag, input int exp_lat);
        int lat = 0;
        while (!res_if.res_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk(tag, lat, exp_lat);
    endtask

    task automatic take(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_value"}, 32'(res_if.res_value), 32'(e.v));
            chk({tag, "_ndigits"}, 32'(res_if.res_ndigits), 32'(e.n));
        end
    endtask

    task automatic count_restart(input string tag);
        int cnt = 0;
        while (restart && cnt < 10) begin
            cnt++;
            tick();
        end
        chk({tag, "_restart_len"}, cnt, 2);
        chk({tag, "_dialing"}, 32'(dialing), 1);
    endtask

    task automatic full_session(input string tag,
                                input int d7, d6, d5, d4, d3, d2, d1,
                                input int cnt);
        dial(d7, d6, d5, d4, d3, d2, d1, cnt, 1'b1);
        wait_valid({tag, "_latency"}, 7);
        take(tag);
        tick();
        chk({tag, "_valid_drop"}, 32'(res_if.res_valid), 0);
        count_restart(tag);
    endtask

    initial begin
        int bad;
        int r7, r6, r5, r4, r3, r2, r1, rc;

        rst_n = 1'b0;
        enable = 1'b0;
        all_done = 1'b1;
        ndial = 3'd0;
        set_digits(0, 0, 0, 0, 0, 0, 0);
        res_if.res_ready = 1'b1;
        #1;
        chk("reset_valid", 32'(res_if.res_valid), 0);
        chk("reset_restart", 32'(restart), 0);
        chk("reset_dialing", 32'(dialing), 0);
        chk("reset_value", 32'(res_if.res_value), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_no_restart", 32'(restart), 0);

        enable = 1'b1;
        tick();
        chk("first_clear_dialing", 32'(dialing), 0);
        count_restart("first_clear");

        full_session("full7", 7, 6, 5, 4, 3, 2, 1, 7);
        chk("full7_const", 32'(fe_value(7, 6, 5, 4, 3, 2, 1)), 40319);

        full_session("partial3", 0, 0, 0, 0, 3, 2, 1, 3);

        res_if.res_ready = 1'b0;
        dial(0, 0, 0, 0, 0, 2, 1, 2, 1'b1);
        wait_valid("bp_latency", 7);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (!(res_if.res_valid === 1'b1 &&
                  res_if.res_value === 16'd5 && restart === 1'b0))
                bad++;
            tick();
        end
        chk("bp_hold", bad, 0);
        res_if.res_ready = 1'b1;
        take("bp");
        tick();
        chk("bp_valid_drop", 32'(res_if.res_valid), 0);
        chk("bp_single_xfer_sb", 32'(sb.size()), 0);
        count_restart("bp");

        enable = 1'b0;
        tick();
        chk("wb_to_idle_dialing", 32'(dialing), 0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (restart !== 1'b0) bad++;
            tick();
        end
        chk("idle_quiet", bad, 0);
        enable = 1'b1;
        tick();
        chk("rearm_restart", 32'(restart), 1);
        count_restart("rearm");

        dial(1, 2, 3, 4, 1, 1, 1, 7, 1'b0);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midconv_valid", 32'(res_if.res_valid), 0);
        chk("midconv_restart", 32'(restart), 0);
        chk("midconv_dialing", 32'(dialing), 0);
        chk("midconv_value", 32'(res_if.res_value), 0);
        chk("midconv_ndigits", 32'(res_if.res_ndigits), 0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("post_reset_clear", 32'(restart), 1);
        count_restart("post_reset");

        dial(3, 3, 3, 3, 3, 2, 1, 0, 1'b0);
        chk("zero_cnt_restart", 32'(restart), 1);
        chk("zero_cnt_valid", 32'(res_if.res_valid), 0);
        count_restart("zero_cnt");
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (res_if.res_valid !== 1'b0) bad++;
            tick();
        end
        chk("zero_cnt_no_output", bad, 0);

        for (int s = 0; s < 3; s++) begin
            r7 = int'($urandom_range(0, 7));
            r6 = int'($urandom_range(0, 6));
            r5 = int'($urandom_range(0, 5));
            r4 = int'($urandom_range(0, 4));
            r3 = int'($urandom_range(0, 3));
            r2 = int'($urandom_range(0, 2));
            r1 = int'($urandom_range(0, 1));
            rc = int'($urandom_range(1, 7));
            full_session($sformatf("rand%0d", s),
                         r7, r6, r5, r4, r3, r2, r1, rc);
        end

        chk("sb_drained", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dialer_session_ctrl.md
Name: dialer_session_ctrl

Overview:
- Sequences one dialerfe instance through repeated dialing sessions: clears it, waits for the user to dial, captures the 7-digit factorial expansion, converts it to binary, and delivers the result on a valid/ready interface.
- Sits between the rotary-dialer front end and downstream consumers such as the note/pattern loader.
- Conversion is iterative Horner evaluation, one digit per cycle.

Parameters:
- VAL_W, 16, result width. 8!-1 = 40319 fits in 16 bits; the value must be at least 16.
- RESTART_LEN, 2, number of cycles `restart` is held high per clear.

Ports:
- CLK  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  arms sessions while high.
- all_digits_have_been_dialed  in  1  from the front end; high = idle or finished.
- num_of_digits_dialed  in  3  from the front end; 0..7.
- of1  in  1  factorial digit 1 (weight 1!).
- of2  in  2  factorial digit 2 (weight 2!).
- of3  in  2  factorial digit 3 (weight 3!).
- of4  in  3  factorial digit 4 (weight 4!).
- of5  in  3  factorial digit 5 (weight 5!).
- of6  in  3  factorial digit 6 (weight 6!).
- of7  in  3  factorial digit 7 (weight 7!).
- restart  out  1  clear pulse to the front end.
- dialing  out  1  high while a session is in progress (states WAIT_BEGIN through OUTPUT).
- res_value  out  VAL_W  converted number.
- res_ndigits  out  3  digit count captured with the value.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE.
  - restart=0, dialing=0, res_valid=0, res_value=0, res_ndigits=0.
  - Capture registers, accumulator and step counter are 0.
- States: IDLE, CLEAR, WAIT_BEGIN, WAIT_END, CONVERT, OUTPUT.
- IDLE:
  - enable=1 moves to CLEAR on the next edge.
  - Otherwise remain in IDLE.
- CLEAR:
  - restart=1 for exactly RESTART_LEN cycles, then go to WAIT_BEGIN.
  - restart is registered, with no combinational path from inputs.
- WAIT_BEGIN:
  - all_digits_have_been_dialed=0 (the user has started dialing) moves to WAIT_END.
  - enable=0 while here returns to IDLE.
- WAIT_END:
  - enable is ignored here.
  - On the first cycle with all_digits_have_been_dialed=1:
    - capture of1..of7 and num_of_digits_dialed into local registers;
    - go to CONVERT if the captured count is at least 1;
    - if the count is 0, go back to CLEAR and produce no output.
- CONVERT, fixed 6 cycles:
  - Initialise acc = of7.
  - Then acc = acc*k + d(k-1) for k = 7, 6, 5, 4, 3, 2, one step per cycle.
  - k is a constant per step; implement as shift-add or a small multiply, and keep all intermediates VAL_W wide.
  - Digit values are taken as-is; the front end guarantees d_k <= k, so no range check is done here.
  - Latency: res_valid rises on the 7th edge after the capture edge.
- OUTPUT:
  - res_valid=1. res_value and res_ndigits stay stable until the handshake.
  - A transfer happens on an edge with res_valid & res_ready. res_valid drops on that edge.
  - Next state after the transfer: CLEAR if enable=1, else IDLE.
  - A dialer that begins dialing while OUTPUT is stalled is not tracked; the digits are discarded by the following CLEAR.
- dialing is registered.
- Reset asserted mid-CONVERT or mid-OUTPUT: abandon immediately with no partial res_valid. restart is not issued until the next CLEAR.
- enable deasserted in CLEAR: finish the pulse, then go to WAIT_BEGIN, which returns to IDLE.

Decomposition:
- Shared package dialer_pkg:
  - FE_DIGITS=7.
  - FE_VAL_W=16.
  - Per-digit widths {1,2,2,3,3,3,3}.
  - State enum encoding for dialer_session_ctrl.
- One natural sub-module, fe_to_bin_seq:
  - Holds the Horner step counter and accumulator.
  - Interface: start pulse, digit vector in, done pulse and value out.
  - The FSM stays in dialer_session_ctrl.

Test Plan:
- Full dial 7654321 (of7..of1 = 7,6,5,4,3,2,1), count 7, res_ready=1 → res_value=40319 and res_ndigits=7, with res_valid rising 7 edges after capture; then restart pulses for 2 cycles.
- Partial dial, count 3, of1=1, of2=2, of3=3, others 0 → res_value=23 (3*6+2*2+1), res_ndigits=3.
- Backpressure: res_ready=0 for 20 cycles with result 5 (of2=2, of1=1) → res_valid held, res_value=5 stable, no restart. res_ready=1 → one transfer, then CLEAR.
- enable=0 in WAIT_BEGIN → IDLE, no restart. enable=1 → single 2-cycle restart, then WAIT_BEGIN.
- rst_n=0 in CONVERT step 3 → all outputs 0 asynchronously, state IDLE; after release with enable=1 → fresh CLEAR.
- Capture with count 0 (forced) → no res_valid, immediate return to CLEAR.
